// File: rtl/reg_file8.sv
// reg_file8: 8 x WIDTH register file for the WISC decode stage.
// It has two combinational read ports and one synchronous write port.
// The write port is decoded by an internal dec8 into one-hot load strobes.
// The optional macro REG_FILE8_BYPASS_EN forwards a same-cycle write to any
// read port that selects the register being written.

// dec8: 3-to-8 one-hot decoder gated by an enable.
module dec8 (
  input  logic [2:0] sel_i,
  input  logic       en_i,
  output logic [7:0] dec_o
);

  // One strobe high for the selected index, all low when disabled
  always_comb begin
    dec_o = '0;
    if (en_i) begin
      dec_o[sel_i] = 1'b1;
    end
  end

endmodule

module reg_file8 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       read1RegSel,
  input  logic [2:0]       read2RegSel,
  input  logic [2:0]       writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic             err
);

  logic [7:0]       load;
  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];

  dec8 u_dec8 (
    .sel_i (writeRegSel),
    .en_i  (writeEn),
    .dec_o (load)
  );

  // Next-state per register: reset clears all and beats any load strobe
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (rst) begin
        regs_d[i] = '0;
      end else if (load[i]) begin
        regs_d[i] = writeData;
      end
    end
  end

  // Register storage
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 8; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Combinational read ports, with optional write-to-read forwarding
  always_comb begin
    read1Data = regs_q[read1RegSel];
    read2Data = regs_q[read2RegSel];
`ifdef REG_FILE8_BYPASS_EN
    if (writeEn && !rst && (read1RegSel == writeRegSel)) begin
      read1Data = writeData;
    end
    if (writeEn && !rst && (read2RegSel == writeRegSel)) begin
      read2Data = writeData;
    end
`else
`endif
  end

  // A write presented during reset is dropped; flag it
  assign err = rst & writeEn;

endmodule

// File: tb/tb_reg_file8.sv
// Self-checking bench for reg_file8 using a reference model and an
// expectation queue. It honours REG_FILE8_BYPASS_EN when that macro is defined.
module tb_reg_file8;

  logic        clk;
  logic        rst;
  logic [2:0]  read1RegSel, read2RegSel, writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic [15:0] read1Data, read2Data;
  logic        err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        e;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mdl [8];

  reg_file8 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] sel, input logic r,
                                             input logic we, input logic [2:0] ws,
                                             input logic [15:0] wd);
    logic [15:0] v;
    v = mdl[sel];
`ifdef REG_FILE8_BYPASS_EN
    if (we && !r && sel == ws) v = wd;
`endif
    return v;
  endfunction

  // One cycle: drive inputs just after a rising edge, check at the falling
  // edge, then update the model at the next rising edge.
  task automatic step(input string tag, input logic r, input logic we,
                      input logic [2:0] ws, input logic [15:0] wd,
                      input logic [2:0] s1, input logic [2:0] s2);
    exp_t x, got;
    rst = r; writeEn = we; writeRegSel = ws; writeData = wd;
    read1RegSel = s1; read2RegSel = s2;
    x.tag = tag;
    x.r1  = model_read(s1, r, we, ws, wd);
    x.r2  = model_read(s2, r, we, ws, wd);
    x.e   = r & we;
    sbq.push_back(x);
    @(negedge clk);
    got = sbq.pop_front();
    check({got.tag, ".rd1"}, read1Data, got.r1);
    check({got.tag, ".rd2"}, read2Data, got.r2);
    check({got.tag, ".err"}, {15'b0, err}, {15'b0, got.e});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    end else if (we) begin
      mdl[ws] = wd;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; writeEn = 1'b0; writeRegSel = '0; writeData = '0;
    read1RegSel = '0; read2RegSel = '0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    @(posedge clk);
    #1;

    // Reset, then read every index on both ports
    step("rst_hold", 1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd1);
    for (int i = 0; i < 8; i++)
      step("rst_read", 1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));

    // Fill R_i = 0x1111*i, including R0
    for (int i = 0; i < 8; i++)
      step("fill", 1'b0, 1'b1, 3'(i), 16'(16'h1111 * i), 3'd0, 3'd7);
    step("rb07", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7);
    step("rb34", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd4);

    // Write gating: writeEn low must not disturb R5
    step("gate", 1'b0, 1'b0, 3'd5, 16'hDEAD, 3'd5, 3'd2);
    for (int i = 0; i < 8; i++)
      step("gate_rd", 1'b0, 1'b0, 3'd5, 16'hDEAD, 3'(i), 3'(7 - i));

    // Same-cycle read-after-write on R2, then port 2 on R1
    step("raw_r2", 1'b0, 1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd7);
    step("raw_nxt", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd2);
    step("raw_p2", 1'b0, 1'b1, 3'd1, 16'hC0DE, 3'd0, 3'd1);
    step("raw_p2n", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd0);

    // Reset beats a simultaneous write
    step("rst_wr", 1'b1, 1'b1, 3'd6, 16'hFFFF, 3'd6, 3'd2);
    step("rst_wr6", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd2);

    // Dual-port read of the same index
    step("wr_a5", 1'b0, 1'b1, 3'd3, 16'hA5A5, 3'd4, 3'd5);
    step("dual3", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);

    // Random traffic against the model
    for (int n = 0; n < 40; n++)
      step("rand", ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sbq_drain: got %0d required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
